// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the result-path sequencer: mux select codes and FSM encoding.
package alu_sequencer_pkg;

  localparam logic [2:0] SEL_ALU  = 3'b000;
  localparam logic [2:0] SEL_SLTI = 3'b001;
  localparam logic [2:0] SEL_SLL  = 3'b110;
  localparam logic [2:0] SEL_SRA  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  function automatic logic is_shift(logic [2:0] op);
    return (op == SEL_SLL) || (op == SEL_SRA);
  endfunction

endpackage

// File: rtl/alu_sequencer_shift_step.sv
// One-bit shift step: logical left when arith_i is low, arithmetic right when high.
module shift_step (
  input  logic        arith_i,
  input  logic [15:0] data_i,
  output logic [15:0] data_o
);

  always_comb begin
    if (arith_i) begin
      data_o = {data_i[15], data_i[15:1]};
    end else begin
      data_o = {data_i[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the 16-bit result path; SLL/SRA run bit-serially,
// one position per cycle, and Done pulses for one cycle when the result is valid.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [15:0] A,
  input  logic [3:0]  ShAmt,
  output logic [2:0]  MuxSel,
  output logic [15:0] ShiftOut,
  output logic        Busy,
  output logic        Done
);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] step_out;

  // op_q[0] distinguishes SRA (111) from SLL (110) while shifting.
  shift_step u_shift_step (
    .arith_i (op_q[0]),
    .data_i  (shift_q),
    .data_o  (step_out)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= 3'b000;
      shift_q <= 16'h0000;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (Start) begin
          op_d    = Op;
          shift_d = A;
          cnt_d   = ShAmt;
          state_d = (is_shift(Op) && (ShAmt != 4'd0)) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        shift_d = step_out;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs depend on registered state only.
  always_comb begin
    MuxSel   = (state_q == IDLE) ? SEL_ALU : op_q;
    ShiftOut = shift_q;
    Busy     = (state_q != IDLE);
    Done     = (state_q == DONE);
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: latency, result, select and busy/done handshake.
module tb_alu_sequencer;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [2:0]  Op;
  logic [15:0] A;
  logic [3:0]  ShAmt;
  logic [2:0]  MuxSel;
  logic [15:0] ShiftOut;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_errors = 0;

  alu_sequencer dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .ShAmt    (ShAmt),
    .MuxSel   (MuxSel),
    .ShiftOut (ShiftOut),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Inputs are scrambled right after the
  // accept edge; pulse keeps Start high through the busy window including DONE.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [3:0] sh, input logic pulse, input int exp_cyc,
                       input logic [15:0] exp_out, input logic [2:0] exp_sel);
    int         done_cyc;
    logic       sel_ok;
    logic [15:0] got_out;
    done_cyc = 0;
    sel_ok   = 1'b1;
    got_out  = 16'h0;
    Start = 1'b1;
    Op    = op;
    A     = a;
    ShAmt = sh;
    @(posedge Clock);
    #1;
    Start = pulse;
    Op    = 3'b010;
    A     = ~a;
    ShAmt = sh + 4'd5;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clock);
      if (MuxSel !== exp_sel || Busy !== 1'b1) sel_ok = 1'b0;
      if (Done === 1'b1) begin
        done_cyc = c;
        got_out  = ShiftOut;
        break;
      end
    end
    @(posedge Clock);
    #1;
    Start = 1'b0;
    check_eq({tag, "_latency"}, done_cyc, exp_cyc);
    check_eq({tag, "_result"}, {16'h0, got_out}, {16'h0, exp_out});
    check_eq({tag, "_sel_busy"}, {31'h0, sel_ok}, 32'd1);
    @(negedge Clock);
    check_eq({tag, "_idle_busy"}, {31'h0, Busy}, 32'd0);
    check_eq({tag, "_idle_done"}, {31'h0, Done}, 32'd0);
    check_eq({tag, "_idle_sel"}, {29'h0, MuxSel}, 32'd0);
  endtask

  initial begin
    int dones;
    Reset = 1'b1;
    Start = 1'b0;
    Op    = 3'b000;
    A     = 16'h0;
    ShAmt = 4'd0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_eq("rst_sel", {29'h0, MuxSel}, 32'd0);
    check_eq("rst_shift", {16'h0, ShiftOut}, 32'd0);
    check_eq("rst_busy", {31'h0, Busy}, 32'd0);
    check_eq("rst_done", {31'h0, Done}, 32'd0);
    Reset = 1'b0;

    do_op("sll4",    3'b110, 16'h0001, 4'd4,  1'b0, 5,  16'h0010, 3'b110);
    do_op("sra15",   3'b111, 16'h8000, 4'd15, 1'b0, 16, 16'hFFFF, 3'b111);
    do_op("slti",    3'b001, 16'hABCD, 4'd7,  1'b0, 1,  16'hABCD, 3'b001);
    do_op("alu",     3'b000, 16'h0F0F, 4'd5,  1'b0, 1,  16'h0F0F, 3'b000);
    do_op("sll0",    3'b110, 16'h1234, 4'd0,  1'b0, 1,  16'h1234, 3'b110);
    do_op("op100",   3'b100, 16'h5555, 4'd3,  1'b0, 1,  16'h5555, 3'b100);
    do_op("sra_pos", 3'b111, 16'h7F00, 4'd4,  1'b0, 5,  16'h07F0, 3'b111);
    do_op("busy_st", 3'b111, 16'h9000, 4'd3,  1'b1, 4,  16'hF200, 3'b111);
    do_op("hold",    3'b110, 16'h00FF, 4'd8,  1'b0, 9,  16'hFF00, 3'b110);

    // Reset during the 4th SHIFT cycle of an SLL by 9.
    Start = 1'b1;
    Op    = 3'b110;
    A     = 16'h0001;
    ShAmt = 4'd9;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    check_eq("mid_shift", {16'h0, ShiftOut}, 32'h0008);
    check_eq("mid_busy", {31'h0, Busy}, 32'd1);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    check_eq("mrst_busy", {31'h0, Busy}, 32'd0);
    check_eq("mrst_sel", {29'h0, MuxSel}, 32'd0);
    check_eq("mrst_shift", {16'h0, ShiftOut}, 32'd0);
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (Done === 1'b1) dones++;
      @(negedge Clock);
    end
    check_eq("mrst_no_done", dones, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
